// File: rtl/regbank_ctrl_pkg.sv
// Shared sizes and sequencer state encoding for the register-bank front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbank_ctrl_pkg;

    localparam int RB_NREG = 16;
    localparam int RB_AW   = 4;
    localparam int RB_DW   = 16;
    localparam logic [RB_NREG-1:0] RB_DAC_MASK = 16'hFFFF;

    // Update sequencer: pick a dirty register, capture its read data, offer it.
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_CAP   = 2'd1,
        SEQ_OFFER = 2'd2
    } seq_state_t;

endpackage

// File: rtl/regbank_ctrl_rr_find.sv
// Round-robin search: first set bit of vec at or after start, wrapping past the top index.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (candidates), start (search origin), idx (winner), found (any bit set).
// N must equal 2**W so the index arithmetic wraps naturally.
module regbank_ctrl_rr_find #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // Walk offsets from the far end back to zero so the nearest hit is the last one kept.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = start + W'(i);
            if (vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_ctrl.sv
// Register-bank front end: round-robin write-port arbiter (host vs ADC) plus dirty-register update sequencer.
// Latency: write req sampled at edge N -> bank commit at N+1; host write to idle sequencer -> upd_valid from N+3.
// Backpressure: requests are held until their wack pulse; an offered update holds stable until upd_ready.
// Ports: host_w*/adc_w* request sides with wack pulses; rb_* bank write/read port; upd_* update stream;
//        scan_en gates new scans; dirty exposes the pending-update bitmap.
module regbank_ctrl
    import regbank_ctrl_pkg::*;
#(
    parameter int NREG = RB_NREG,
    parameter int AW   = RB_AW,
    parameter int DW   = RB_DW,
    parameter logic [NREG-1:0] DAC_MASK = RB_DAC_MASK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_wreq,
    input  logic [AW-1:0]   host_waddr,
    input  logic [DW-1:0]   host_wdata,
    output logic            host_wack,
    input  logic            adc_wreq,
    input  logic [AW-1:0]   adc_waddr,
    input  logic [DW-1:0]   adc_wdata,
    output logic            adc_wack,
    output logic            rb_write,
    output logic [AW-1:0]   rb_waddr,
    output logic [DW-1:0]   rb_wdata,
    output logic [AW-1:0]   rb_raddr,
    input  logic [DW-1:0]   rb_rdata,
    input  logic            scan_en,
    output logic            upd_valid,
    output logic [AW-1:0]   upd_addr,
    output logic [DW-1:0]   upd_data,
    input  logic            upd_ready,
    output logic [NREG-1:0] dirty
);

    // ---------------- write-port arbiter ----------------
    logic prio_adc;     // 0: host holds priority, 1: ADC holds priority
    logic wsrc_host;    // the write currently on rb_* came from the host
    logic host_elig, adc_elig, grant_host, grant_adc;

    // A request whose wack is high this cycle was just served; ignoring it avoids a double grant.
    always_comb begin
        host_elig  = host_wreq & ~host_wack;
        adc_elig   = adc_wreq & ~adc_wack;
        grant_host = host_elig & (~adc_elig | ~prio_adc);
        grant_adc  = adc_elig & ~grant_host;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_write  <= 1'b0;
            rb_waddr  <= '0;
            rb_wdata  <= '0;
            host_wack <= 1'b0;
            adc_wack  <= 1'b0;
            wsrc_host <= 1'b0;
            prio_adc  <= 1'b0;
        end else begin
            rb_write  <= grant_host | grant_adc;
            host_wack <= grant_host;
            adc_wack  <= grant_adc;
            wsrc_host <= grant_host;
            if (grant_host) begin
                rb_waddr <= host_waddr;
                rb_wdata <= host_wdata;
            end else if (grant_adc) begin
                rb_waddr <= adc_waddr;
                rb_wdata <= adc_wdata;
            end
            // Priority only moves on contention: it passes to the side that lost.
            if (host_elig && adc_elig) begin
                prio_adc <= ~prio_adc;
            end
        end
    end

    // ---------------- update sequencer ----------------
    seq_state_t state, state_nxt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   pick_idx;
    logic            pick_found;
    logic            do_pick, do_cap, do_accept;
    logic [NREG-1:0] dirty_set, dirty_clr;

    regbank_ctrl_rr_find #(.N(NREG), .W(AW)) u_find (
        .vec   (dirty),
        .start (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // scan_en only gates leaving IDLE; a word already picked runs to completion.
    always_comb begin
        state_nxt = state;
        do_pick   = 1'b0;
        do_cap    = 1'b0;
        do_accept = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (scan_en && pick_found) begin
                    do_pick   = 1'b1;
                    state_nxt = SEQ_CAP;
                end
            end
            SEQ_CAP: begin
                do_cap    = 1'b1;
                state_nxt = SEQ_OFFER;
            end
            SEQ_OFFER: begin
                if (upd_valid && upd_ready) begin
                    do_accept = 1'b1;
                    state_nxt = SEQ_IDLE;
                end
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    // A host commit landing on the capture edge re-marks the bit, so the new data goes out later.
    always_comb begin
        dirty_set = '0;
        dirty_clr = '0;
        if (rb_write && wsrc_host && DAC_MASK[rb_waddr]) begin
            dirty_set[rb_waddr] = 1'b1;
        end
        if (do_cap) begin
            dirty_clr[rb_raddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dirty     <= '0;
            ptr       <= '0;
            rb_raddr  <= '0;
            upd_valid <= 1'b0;
            upd_addr  <= '0;
            upd_data  <= '0;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            if (do_pick) begin
                rb_raddr <= pick_idx;
            end
            if (do_cap) begin
                upd_data  <= rb_rdata;
                upd_addr  <= rb_raddr;
                upd_valid <= 1'b1;
            end
            if (do_accept) begin
                upd_valid <= 1'b0;
                ptr       <= upd_addr + AW'(1);
            end
        end
    end

endmodule
